// File: rtl/cpu6_bus_pkg.sv
// Shared constants for the CPU6 bus controller: register offsets, status bits, serializer states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu6_bus_pkg;

    localparam int STAT_RX_RDY   = 0;
    localparam int STAT_TX_NFULL = 1;
    localparam int STAT_TX_IDLE  = 2;
    localparam int STAT_OVF      = 7;

    localparam logic [15:0] REG_STATUS = 16'd0;
    localparam logic [15:0] REG_DATA   = 16'd1;

    localparam logic [7:0] DEFAULT_RD = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } ser_state_t;

endpackage

// File: rtl/cpu6_uart_tx.sv
// 8N1 LSB-first serializer fed from the TX FIFO head, with its own baud counter.
// Latency: pops one clock after the FIFO goes non-empty; frame is 10*CLK_DIV clocks.
// Backpressure: pops only in IDLE, so the FIFO holds bytes while a frame is on the line.
module cpu6_uart_tx
    import cpu6_bus_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dat,
    output logic       pop,
    output logic       tx,
    output logic       ser_idle
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    ser_state_t  state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  sh, sh_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            sh      <= sh_nx;
        end
    end

    // tx decodes straight from state so a reset returns the line high without a clock
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        sh_nx    = sh;
        pop      = 1'b0;
        tx       = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sh_nx    = fifo_dat;
                    cnt_nx   = RELOAD;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (cnt == 16'd0) begin
                    cnt_nx   = RELOAD;
                    bit_nx   = 3'd0;
                    state_nx = ST_DATA;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            ST_DATA: begin
                tx = sh[bit_idx];
                if (cnt == 16'd0) begin
                    cnt_nx = RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_nx = ST_STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt == 16'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign ser_idle = (state == ST_IDLE);

endmodule

// File: rtl/cpu6_bus_ctrl.sv
// CPU6 bus slave: low RAM plus MUX serial port (TX FIFO + serializer); MUX_RX_EN adds the receiver.
// Latency: dataInBus reflects the address present at the previous rising edge (one cycle).
// Backpressure: none toward the CPU; pushes to a full FIFO are dropped and flag overflow.
module cpu6_bus_ctrl
    import cpu6_bus_pkg::*;
#(
    parameter int          RAM_ADDR_BITS = 12,
    parameter logic [15:0] MUX_BASE      = 16'hF200,
    parameter int          CLK_DIV       = 16,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic [7:0]  dataOutBus,
    input  logic        writeEnBus,
    output logic [7:0]  dataInBus,
    output logic        tx,
    output logic        tx_busy
`ifdef MUX_RX_EN
    ,
    input  logic        rx
`endif
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic is_ram, is_status, is_data;
    logic [RAM_ADDR_BITS-1:0] ram_idx;

    assign is_ram    = ((addressBus >> RAM_ADDR_BITS) == 16'd0);
    assign ram_idx   = addressBus[RAM_ADDR_BITS-1:0];
    assign is_status = (addressBus == (MUX_BASE + REG_STATUS));
    assign is_data   = (addressBus == (MUX_BASE + REG_DATA));

    logic [7:0] ram [2**RAM_ADDR_BITS];
    logic [7:0] ram_q;

    // Read-before-write: ram_q picks up the old byte when read and write share an address
    always_ff @(posedge clock) begin
        if (writeEnBus && is_ram) begin
            ram[ram_idx] <= dataOutBus;
        end
        ram_q <= ram[ram_idx];
    end

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic fifo_empty, fifo_full, push_req, push_ok, pop, ser_idle, tx_idle;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push_req   = writeEnBus && is_data;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign tx_idle    = fifo_empty && ser_idle;
    assign tx_busy    = !tx_idle;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= dataOutBus;
        end
    end

    cpu6_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dat   (fifo_mem[rd_ptr]),
        .pop        (pop),
        .tx         (tx),
        .ser_idle   (ser_idle)
    );

    logic       rx_ready, rx_done;
    logic [7:0] data_rd;

`ifdef MUX_RX_EN
    localparam logic [15:0] RX_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] RX_HALF   = 16'(CLK_DIV / 2 - 1);

    logic        rx_s1, rx_s2, rx_s3;
    ser_state_t  rx_state, rx_state_nx;
    logic [15:0] rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_idx, rx_idx_nx;
    logic [7:0]  rx_sh, rx_sh_nx, rx_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_hold  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_sh    <= rx_sh_nx;
            if (rx_done) begin
                rx_hold  <= rx_sh;
                rx_ready <= 1'b1;
            end else if (is_data && !writeEnBus) begin
                rx_ready <= 1'b0;
            end
        end
    end

    // First sample lands mid start bit, then every CLK_DIV clocks after that
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_idx_nx   = rx_idx;
        rx_sh_nx    = rx_sh;
        rx_done     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_cnt_nx   = RX_HALF;
                    rx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_s2) begin
                        rx_state_nx = ST_IDLE;
                    end else begin
                        rx_cnt_nx   = RX_RELOAD;
                        rx_idx_nx   = 3'd0;
                        rx_state_nx = ST_DATA;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_sh_nx[rx_idx] = rx_s2;
                    rx_cnt_nx        = RX_RELOAD;
                    if (rx_idx == 3'd7) begin
                        rx_state_nx = ST_STOP;
                    end else begin
                        rx_idx_nx = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_done     = rx_s2;
                    rx_state_nx = ST_IDLE;
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    assign data_rd = rx_hold;
`else
    assign rx_ready = 1'b0;
    assign rx_done  = 1'b0;
    assign data_rd  = DEFAULT_RD;
`endif

    logic [7:0] status_val;
    logic       ovf, ovf_set, sel_ram_q;
    logic [7:0] rd_q;

    always_comb begin
        status_val                = '0;
        status_val[STAT_RX_RDY]   = rx_ready;
        status_val[STAT_TX_NFULL] = !fifo_full;
        status_val[STAT_TX_IDLE]  = tx_idle;
        status_val[STAT_OVF]      = ovf;
    end

    assign ovf_set = (push_req && !push_ok) || (rx_done && rx_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_ram_q <= 1'b0;
            rd_q      <= DEFAULT_RD;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            sel_ram_q <= is_ram;
            if (is_status) begin
                rd_q <= status_val;
            end else if (is_data) begin
                rd_q <= data_rd;
            end else begin
                rd_q <= DEFAULT_RD;
            end
            // A fresh overflow event wins over the read-clear on the same edge
            if (is_status) ovf <= 1'b0;
            if (ovf_set)   ovf <= 1'b1;
            if (push_ok)   wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dataInBus = sel_ram_q ? ram_q : rd_q;

endmodule

// File: tb/tb_cpu6_bus_ctrl.sv
// Directed bench for cpu6_bus_ctrl: RAM/decode, STATUS, TX framing, FIFO overflow, async reset.
// A negedge-sampled line decoder collects transmitted bytes for the ordering checks.
module tb_cpu6_bus_ctrl;

    localparam int CLK_DIV = 4;
    localparam logic [15:0] A_STATUS = 16'hF200;
    localparam logic [15:0] A_DATA   = 16'hF201;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addressBus = 16'h0000;
    logic [7:0]  dataOutBus = 8'h00;
    logic        writeEnBus = 1'b0;
    logic [7:0]  dataInBus;
    logic        tx;
    logic        tx_busy;
`ifdef MUX_RX_EN
    logic        rx = 1'b1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    cpu6_bus_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .dataOutBus (dataOutBus),
        .writeEnBus (writeEnBus),
        .dataInBus  (dataInBus),
        .tx         (tx),
        .tx_busy    (tx_busy)
`ifdef MUX_RX_EN
        ,
        .rx         (rx)
`endif
    );

    always #5 clock = ~clock;

    logic [7:0] mon_q[$];
    int         mon_bad = 0;
    logic       mact = 1'b0;
    int         mcnt;
    int         mj;
    logic [7:0] msh;

    // Line decoder: bit j occupies samples CLK_DIV*j .. CLK_DIV*j+CLK_DIV-1 after the start edge
    always @(negedge clock) begin
        if (reset) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (tx == 1'b0) begin
                mact = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt = mcnt + 1;
            if (mcnt % CLK_DIV == CLK_DIV / 2) begin
                mj = mcnt / CLK_DIV;
                if (mj == 0) begin
                    if (tx) mact = 1'b0;
                end else if (mj <= 8) begin
                    msh[mj-1] = tx;
                end else begin
                    if (tx !== 1'b1) mon_bad++;
                    mon_q.push_back(msh);
                    mact = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addressBus = a;
        dataOutBus = d;
        writeEnBus = 1'b1;
        tick();
        writeEnBus = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addressBus = a;
        tick();
        check(tag, dataInBus, exp);
    endtask

`ifdef MUX_RX_EN
    task automatic send_rx(input logic [7:0] b);
        rx = 1'b0;
        repeat (CLK_DIV) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CLK_DIV) tick();
        end
        rx = 1'b1;
        repeat (CLK_DIV) tick();
        repeat (8) tick();
    endtask
`endif

    logic [39:0] cap, expv;
    logic [7:0]  b55;

    initial begin
        // Reset values, observed while reset is held
        #2 reset = 1'b1;
        #2;
        check("reset dataInBus", dataInBus, 8'hFF);
        check("reset tx", tx, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        rd_check("status after reset", A_STATUS, 8'h06);
`ifndef MUX_RX_EN
        rd_check("data read no rx", A_DATA, 8'hFF);
`endif
        rd_check("unmapped read", 16'hF202, 8'hFF);

        // RAM write/read, read-before-write, decode boundaries
        bus_write(16'h0123, 8'hA5);
        rd_check("ram read 0123", 16'h0123, 8'hA5);
        bus_write(16'h0123, 8'h5A);
        check("ram read-before-write", dataInBus, 8'hA5);
        rd_check("ram new byte", 16'h0123, 8'h5A);
        bus_write(16'h0FFF, 8'hE7);
        rd_check("ram top byte", 16'h0FFF, 8'hE7);
        bus_write(16'h0000, 8'h3C);
        bus_write(16'h1000, 8'h99);
        check("write 1000 reads ff", dataInBus, 8'hFF);
        bus_write(16'h8000, 8'h77);
        check("write 8000 reads ff", dataInBus, 8'hFF);
        rd_check("read 8000", 16'h8000, 8'hFF);
        rd_check("ram 0000 untouched", 16'h0000, 8'h3C);
        bus_write(A_STATUS, 8'hFF);
        check("status on write cycle", dataInBus, 8'h06);
        rd_check("status write ignored", A_STATUS, 8'h06);

        // Single frame 0x55, captured sample by sample
        mon_q.delete();
        bus_write(A_DATA, 8'h55);
        addressBus = 16'h0000;
        check("busy after push", tx_busy, 1'b1);
        check("tx idle before pop", tx, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            cap[i] = tx;
        end
        b55 = 8'h55;
        for (int i = 0; i < 40; i++) begin
            if (i / CLK_DIV == 0)      expv[i] = 1'b0;
            else if (i / CLK_DIV == 9) expv[i] = 1'b1;
            else                       expv[i] = b55[i/CLK_DIV-1];
        end
        check("frame 0x55 waveform", cap, expv);
        check("busy in last stop clock", tx_busy, 1'b1);
        tick();
        check("busy drops after frame", tx_busy, 1'b0);
        check("tx high after frame", tx, 1'b1);
        check("decoded frame count", mon_q.size(), 1);
        if (mon_q.size() == 1) check("decoded 0x55", mon_q[0], 8'h55);

        // Ten back-to-back pushes: nine accepted, tenth dropped
        mon_q.delete();
        for (int i = 0; i < 10; i++) begin
            bus_write(A_DATA, 8'h10 + 8'(i));
        end
        rd_check("status overflow", A_STATUS, 8'h80);
        rd_check("status overflow cleared", A_STATUS, 8'h00);
        addressBus = 16'h0000;
        for (int k = 0; k < 2000 && tx_busy; k++) tick();
        check("fifo drained", tx_busy, 1'b0);
        repeat (2) tick();
        check("frames emitted", mon_q.size(), 9);
        for (int i = 0; i < 9 && i < mon_q.size(); i++) begin
            check($sformatf("frame %0d byte", i), mon_q[i], 8'h10 + 8'(i));
        end
        check("stop bits high", mon_bad, 0);
        rd_check("status after drain", A_STATUS, 8'h06);

        // Reset in the middle of the data bits of a 0x00 byte
        bus_write(A_DATA, 8'h00);
        bus_write(A_DATA, 8'h00);
        addressBus = 16'h0000;
        repeat (10) tick();
        check("tx low mid data", tx, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async reset tx", tx, 1'b1);
        check("async reset busy", tx_busy, 1'b0);
        check("async reset dataInBus", dataInBus, 8'hFF);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        rd_check("status after mid-frame reset", A_STATUS, 8'h06);
        repeat (3) tick();
        check("tx stays idle after reset", tx, 1'b1);

`ifdef MUX_RX_EN
        send_rx(8'h3C);
        rd_check("rx ready", A_STATUS, 8'h07);
        rd_check("rx data", A_DATA, 8'h3C);
        rd_check("rx ready cleared", A_STATUS, 8'h06);
        send_rx(8'hA1);
        send_rx(8'h5E);
        rd_check("rx overflow", A_STATUS, 8'h87);
        rd_check("rx overwritten", A_DATA, 8'h5E);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu6_bus_ctrl.md
Name: cpu6_bus_ctrl

Overview:
Memory and I/O bus controller directly downstream of the CPU6 core. It consumes the core's address, write-data and write-enable, and returns read data on the core's data-in bus. It holds the low RAM and a memory-mapped MUX serial port with a transmit FIFO and a bit serializer. It is the CPU's only bus slave on the iCE40 build.

Parameters:
RAM_ADDR_BITS, 12, RAM size is 2**RAM_ADDR_BITS bytes, mapped at 0x0000.
MUX_BASE, 16'hF200, status register address; MUX_BASE+1 is the data register.
CLK_DIV, 16, clocks per serial bit, legal range 2..65535.
FIFO_DEPTH, 8, TX FIFO entries, power of two, 2..64.

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high
addressBus  in  16  CPU memory address
dataOutBus  in  8  CPU write data
writeEnBus  in  1  write strobe, sampled at the rising edge
dataInBus  out  8  read data to CPU, registered
tx  out  1  serial transmit line, idle high
tx_busy  out  1  high while the FIFO is non-empty or the serializer is not IDLE
rx  in  1  serial receive line (present only with MUX_RX_EN)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, with ports named clock and reset.
- Reset values: dataInBus=0xFF, tx=1, tx_busy=0, FIFO empty, overflow=0, serializer IDLE, rx_ready=0. A reset mid-frame aborts the frame and forces tx high immediately.
- Address decode: RAM when addressBus < 2**RAM_ADDR_BITS; STATUS at MUX_BASE; DATA at MUX_BASE+1. All other addresses read 0xFF and ignore writes.
- Read latency:
  - dataInBus is re-registered every rising edge from the address present at that edge, so latency is one cycle. The CPU holds the address at least one cycle before it samples.
  - The RAM read is synchronous and read-before-write. A write and a read to the same address in one cycle return the old byte.
- Writes: on a rising edge with writeEnBus=1, the byte is written to RAM or pushed to the TX FIFO (DATA address). A write to STATUS has no effect.
- STATUS read value: bit0 rx_ready, bit1 TX FIFO not full, bit2 TX idle (FIFO empty and serializer IDLE), bit7 overflow, other bits 0. Reading STATUS clears overflow on the same edge; the returned value shows the pre-clear state.
- FIFO:
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH's width plus 1 bit.
- Serializer FSM (8N1, LSB first):
  - IDLE: tx=1. If the FIFO is non-empty, pop one byte and go to START.
  - START: tx=0 for CLK_DIV clocks, then go to DATA.
  - DATA: 8 bits, CLK_DIV clocks each, bit index 0..7.
  - STOP: tx=1 for CLK_DIV clocks, then go to IDLE.
  - A frame is 10*CLK_DIV clocks. Back-to-back bytes add one IDLE clock between the STOP and the next START.
- The baud counter runs only outside IDLE and reloads at each state change.

Optional Feature:
MUX_RX_EN
- Defined:
  - The rx port exists and passes through a 2-FF synchronizer.
  - A falling edge in idle starts a frame. Sampling happens at mid-bit (CLK_DIV/2, then every CLK_DIV clocks).
  - If the start bit re-samples high, the frame is discarded.
  - A valid stop bit loads a 1-byte holding register and sets rx_ready. A stop bit sampled low discards the byte.
  - A DATA read returns the holding register and clears rx_ready.
  - A new byte arriving while rx_ready=1 overwrites the holding register and sets overflow.
- Undefined: no rx port. STATUS bit0 reads 0. A DATA read returns 0xFF.

Decomposition:
- Package cpu6_bus_pkg: status bit-position constants, register offsets (STATUS=0, DATA=1), serializer state encoding (IDLE, START, DATA, STOP), and a default-read constant 0xFF.
- One sub-module: cpu6_uart_tx (FIFO-fed serializer plus baud counter). The top level keeps decode, RAM, the FIFO and the read mux.

Test Plan:
- Reset, then hold addressBus=0x0000 -> dataInBus=0xFF, then the RAM contents after one clock; tx=1, tx_busy=0, STATUS reads 0x06.
- Write 0xA5 to 0x0123, then set the address to 0x0123 -> dataInBus=0xA5 one cycle later. An access to 0x8000 -> 0xFF, and no RAM write occurs.
- Write 0x55 to 0xF201 with CLK_DIV=4 -> tx shows low 4 clocks, bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks. tx_busy drops after 40 clocks.
- Write 10 bytes back-to-back with CLK_DIV=16 -> 9 accepted (8 in FIFO plus 1 popped to the serializer), 10th dropped. STATUS=0x80 after the 10th write, then 0x00 on the next read; all 9 frames emitted in order.
- Reset asserted mid-DATA -> tx=1 asynchronously and FIFO empty; after release, STATUS=0x06.
- MUX_RX_EN: drive 0x3C on rx at CLK_DIV=8 -> STATUS bit0=1, DATA reads 0x3C, then bit0=0. A second byte sent without a read sets bit7.
